// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, PSR layout, FSM encoding.
// The PSR masks select which captured ALU flags an opcode may commit.
package alu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_LSH  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_ADDU = 4'h6;
  localparam logic [3:0] OP_ADDC = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_SUB  = 4'h9;
  localparam logic [3:0] OP_SUBC = 4'hA;
  localparam logic [3:0] OP_CMP  = 4'hB;
  localparam logic [3:0] OP_ASHU = 4'hC;
  localparam logic [3:0] OP_MOV  = 4'hD;
  localparam logic [3:0] OP_RSH  = 4'hE;
  localparam logic [3:0] OP_ALSH = 4'hF;

  localparam int PSR_Z = 4;
  localparam int PSR_C = 3;
  localparam int PSR_O = 2;
  localparam int PSR_L = 1;
  localparam int PSR_N = 0;

  localparam logic [4:0] PSR_MASK_NONE  = 5'b00000;
  localparam logic [4:0] PSR_MASK_ARITH = 5'b01100;
  localparam logic [4:0] PSR_MASK_CMP   = 5'b10011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Logical ops treat imm8 as a bit pattern; everything else treats it as signed.
  function automatic logic imm_zext(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
  endfunction

  function automatic logic [4:0] psr_mask(input logic [3:0] op);
    case (op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: psr_mask = PSR_MASK_ARITH;
      OP_CMP:                           psr_mask = PSR_MASK_CMP;
      default:                          psr_mask = PSR_MASK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction handshake between the fetch side and the issue stage.
// A transfer happens on a rising clk edge where in_valid && in_ready; the source
// holds in_valid/in_instr/in_imm stable until that edge, and in_valid never waits on in_ready.
interface alu_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        in_imm;

  modport master (output in_valid, output in_instr, output in_imm, input in_ready);
  modport slave  (input in_valid, input in_instr, input in_imm, output in_ready);
endinterface

// File: rtl/alu_issue_stage_regfile.sv
// General register file: one write port, two operand read ports and a debug read port.
// Reads are combinational; the write lands on the rising edge.
module alu_issue_stage_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [AW-1:0]     raddr_d,
  output logic [DATA_W-1:0] rdata_d
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
  assign rdata_d = regs[raddr_d];

endmodule

// File: rtl/alu_issue_stage.sv
// Decode / operand-fetch / writeback wrapper around an external combinational ALU.
// One instruction per three cycles: READ registers operands, EXEC captures the ALU, WB commits.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_stage_if.slave  in_if,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [4:0]        alu_flags,
  output logic [4:0]        psr,
  output logic              done,
  output logic              wb_en,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output state_t            dbg_state
);

  localparam int AW = $clog2(NREGS);

  state_t            state, state_nxt;
  logic [15:0]       instr_q;
  logic              imm_q;
  logic [DATA_W-1:0] res_q;
  logic [4:0]        flags_q;
  logic              accept;
  logic              ready_c;
  logic [DATA_W-1:0] rdata_a, rdata_b, imm_ext, wdata;
  logic [3:0]        op_q;
  logic [7:0]        imm8;

  assign op_q      = instr_q[15:12];
  assign imm8      = instr_q[7:0];
  assign dbg_state = state;
  assign in_if.in_ready = ready_c;

  assign imm_ext = imm_zext(op_q) ? {{(DATA_W-8){1'b0}}, imm8}
                                  : {{(DATA_W-8){imm8[7]}}, imm8};

  // MOV commits the already-registered B operand rather than the ALU result.
  assign wdata = (op_q == OP_MOV) ? alu_b : res_q;

  alu_issue_stage_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_en),
    .waddr   (AW'(instr_q[11:8])),
    .wdata   (wdata),
    .raddr_a (AW'(instr_q[11:8])),
    .rdata_a (rdata_a),
    .raddr_b (AW'(instr_q[7:4])),
    .rdata_b (rdata_b),
    .raddr_d (AW'(dbg_addr)),
    .rdata_d (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    wb_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (in_if.in_valid) begin
          accept    = 1'b1;
          state_nxt = ST_READ;
        end
      end
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_WB;
      ST_WB: begin
        done    = 1'b1;
        wb_en   = (op_q != OP_NOP) && (op_q != OP_CMP);
        ready_c = 1'b1;
        if (in_if.in_valid) begin
          accept    = 1'b1;
          state_nxt = ST_READ;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= '0;
      imm_q      <= 1'b0;
      alu_opcode <= OP_NOP;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      res_q      <= '0;
      flags_q    <= '0;
      psr        <= '0;
    end else begin
      if (accept) begin
        instr_q <= in_if.in_instr;
        imm_q   <= in_if.in_imm;
      end
      if (state == ST_READ) begin
        alu_opcode <= op_q;
        alu_a      <= rdata_a;
        alu_b      <= imm_q ? imm_ext : rdata_b;
        alu_cin    <= psr[PSR_C];
      end
      if (state == ST_EXEC) begin
        res_q   <= alu_c;
        flags_q <= alu_flags;
      end
      if (state == ST_WB) begin
        psr <= (psr & ~psr_mask(op_q)) | (flags_q & psr_mask(op_q));
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU on the alu_* ports.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_a, alu_b, alu_c;
  logic        alu_cin;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;
  logic        done, wb_en;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
  state_t      dbg_state;

  int tests_run;
  int tests_failed;
  logic [15:0] exp_q[$];

  alu_issue_stage_if in_if ();

  alu_issue_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (in_if.slave),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_c      (alu_c),
    .alu_flags  (alu_flags),
    .psr        (psr),
    .done       (done),
    .wb_en      (wb_en),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // behavioural ALU: flags {Z,C,O,L,N}
  logic [16:0] m_s;
  logic [15:0] m_c, m_nb;
  logic        m_cy, m_ov;
  always_comb begin
    m_s  = '0;
    m_c  = '0;
    m_cy = 1'b0;
    m_ov = 1'b0;
    m_nb = -alu_b;
    case (alu_opcode)
      OP_AND: m_c = alu_a & alu_b;
      OP_OR:  m_c = alu_a | alu_b;
      OP_XOR: m_c = alu_a ^ alu_b;
      OP_NOT: m_c = ~alu_a;
      OP_MOV: m_c = alu_b;
      OP_LSH: m_c = alu_b[15] ? (alu_a >> m_nb[3:0]) : (alu_a << alu_b[3:0]);
      OP_RSH: m_c = alu_a >> alu_b[3:0];
      OP_ADD, OP_ADDU, OP_ADDC: begin
        m_s  = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, (alu_opcode == OP_ADDC) & alu_cin};
        m_c  = m_s[15:0];
        m_cy = m_s[16];
        m_ov = (alu_a[15] == alu_b[15]) && (m_s[15] != alu_a[15]);
      end
      OP_SUB, OP_SUBC: begin
        m_s  = {1'b0, alu_a} - {1'b0, alu_b} - {16'd0, (alu_opcode == OP_SUBC) & alu_cin};
        m_c  = m_s[15:0];
        m_cy = m_s[16];
        m_ov = (alu_a[15] != alu_b[15]) && (m_s[15] != alu_a[15]);
      end
      default: m_c = '0;
    endcase
    alu_c     = m_c;
    alu_flags = {(alu_opcode == OP_CMP) ? (alu_a == alu_b) : (m_c == 16'd0),
                 m_cy, m_ov, alu_a < alu_b, $signed(alu_a) < $signed(alu_b)};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] rd, input logic [7:0] lo);
    return {op, rd, lo};
  endfunction

  // driver: issue one instruction from IDLE, check latency, wb_en and the destination
  task automatic run_instr(input string tag, input logic [3:0] op, input logic [3:0] rd,
                           input logic [7:0] lo, input logic imm, input logic exp_wb,
                           input logic [15:0] exp_rd);
    int lat;
    @(negedge clk);
    in_if.in_valid = 1'b1;
    in_if.in_instr = enc(op, rd, lo);
    in_if.in_imm   = imm;
    @(posedge clk);
    #1 in_if.in_valid = 1'b0;
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    check({tag, " latency"}, lat, 3);
    check({tag, " wb_en"}, wb_en, exp_wb);
    exp_q.push_back(exp_rd);
    @(negedge clk);
    dbg_addr = rd;
    #1 check({tag, " rd"}, dbg_data, exp_q.pop_front());
  endtask

  initial begin
    int lat;
    tests_run      = 0;
    tests_failed   = 0;
    rst_n          = 1'b0;
    in_if.in_valid = 1'b0;
    in_if.in_instr = '0;
    in_if.in_imm   = 1'b0;
    dbg_addr       = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst in_ready", in_if.in_ready, 1);
    check("rst psr", psr, 0);
    check("rst done", done, 0);
    check("rst alu_opcode", alu_opcode, 0);
    check("rst state", 32'(dbg_state), 32'(ST_IDLE));

    // reset mid-EXEC of ADD R1 imm 5
    @(negedge clk);
    in_if.in_valid = 1'b1;
    in_if.in_instr = enc(OP_ADD, 4'd1, 8'h05);
    in_if.in_imm   = 1'b1;
    @(posedge clk);
    #1 in_if.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre-abort state", 32'(dbg_state), 32'(ST_EXEC));
    rst_n = 1'b0;
    dbg_addr = 4'd1;
    #1;
    check("abort R1", dbg_data, 16'h0000);
    check("abort alu_b", alu_b, 16'h0000);
    check("abort psr", psr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("abort in_ready", in_if.in_ready, 1);
    check("abort R1 later", dbg_data, 16'h0000);
    check("abort done", done, 0);

    // build R1 = 0x7FFF, then overflow it
    run_instr("mov r1",  OP_MOV, 4'd1, 8'h7F, 1'b1, 1'b1, 16'h007F);
    run_instr("lsh r1",  OP_LSH, 4'd1, 8'h08, 1'b1, 1'b1, 16'h7F00);
    run_instr("or r1",   OP_OR,  4'd1, 8'hFF, 1'b1, 1'b1, 16'h7FFF);
    check("psr untouched", psr, 5'b00000);
    run_instr("add ovf", OP_ADD, 4'd1, 8'h01, 1'b1, 1'b1, 16'h8000);
    check("add ovf psr", psr, 5'b00100);

    run_instr("mov r2",  OP_MOV, 4'd2, 8'hFF, 1'b1, 1'b1, 16'hFFFF);
    run_instr("mov r5",  OP_MOV, 4'd5, 8'h03, 1'b1, 1'b1, 16'h0003);
    run_instr("mov r6",  OP_MOV, 4'd6, 8'hFE, 1'b1, 1'b1, 16'hFFFE);
    run_instr("add cy",  OP_ADD, 4'd2, 8'h01, 1'b1, 1'b1, 16'h0000);
    check("add cy psr", psr, 5'b01000);

    run_instr("cmp",     OP_CMP, 4'd5, {4'd6, 4'd0}, 1'b0, 1'b0, 16'h0003);
    check("cmp psr", psr, 5'b01010);

    run_instr("addc",    OP_ADDC, 4'd3, {4'd4, 4'd0}, 1'b0, 1'b1, 16'h0001);
    check("addc psr", psr, 5'b00010);

    run_instr("mov r7",  OP_MOV, 4'd7, 8'hFF, 1'b1, 1'b1, 16'hFFFF);
    run_instr("and r7",  OP_AND, 4'd7, 8'hFF, 1'b1, 1'b1, 16'h00FF);
    run_instr("nop r9",  OP_NOP, 4'd9, 8'h12, 1'b1, 1'b0, 16'h0000);
    check("nop psr", psr, 5'b00010);

    // back-to-back dependency with in_valid held
    @(negedge clk);
    in_if.in_valid = 1'b1;
    in_if.in_instr = enc(OP_MOV, 4'd8, 8'h05);
    in_if.in_imm   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("b2b busy", in_if.in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    check("b2b done1", done, 1);
    check("b2b ready in wb", in_if.in_ready, 1);
    in_if.in_instr = enc(OP_ADD, 4'd8, {4'd8, 4'd0});
    in_if.in_imm   = 1'b0;
    @(posedge clk);
    #1 in_if.in_valid = 1'b0;
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    check("b2b latency", lat, 3);
    check("b2b wb_en", wb_en, 1);
    @(negedge clk);
    dbg_addr = 4'd8;
    #1;
    check("b2b r8", dbg_data, 16'h000A);
    check("b2b psr", psr, 5'b00010);
    dbg_addr = 4'd5;
    #1 check("r5 kept", dbg_data, 16'h0003);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
